// File: rtl/audio_pkg.sv
// Shared audio peripheral definitions: sample/frame geometry and the I2S word-select encoding.
// Used by the I2S transmitter, the oscillators and later the mixer.
package audio_pkg;
  localparam int SAMPLE_W   = 16;
  localparam int FRAME_BITS = 32;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

  localparam logic LR_LEFT  = 1'b0;
  localparam logic LR_RIGHT = 1'b1;

  typedef logic [SAMPLE_W-1:0]  sample_t;
  typedef logic [BIT_CNT_W-1:0] bit_idx_t;

  // Word select leads each channel MSB by one bit slot, so the right half spans slots 15..30.
  localparam bit_idx_t LR_R_FIRST = BIT_CNT_W'(SAMPLE_W - 1);
  localparam bit_idx_t LR_R_LAST  = BIT_CNT_W'(FRAME_BITS - 2);

  function automatic logic lr_for_bit(input bit_idx_t b);
    return (b >= LR_R_FIRST && b <= LR_R_LAST) ? LR_RIGHT : LR_LEFT;
  endfunction
endpackage

// File: rtl/bclk_gen.sv
// Bit clock divider: BCLK toggles every CLK_DIV cycles; 'fall' marks the cycle whose edge
// drives BCLK low, so data updates land on the same edge as the falling bit clock.
module bclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RST_N,
  output logic bclk,
  output logic fall
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          wrap;

  assign wrap = (div_cnt == DIV_LAST);
  assign fall = wrap && bclk;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end
endmodule

// File: rtl/audio_i2s_tx.sv
// Philips I2S transmitter: one 16-bit mono sample per 32-bit frame, sent on both channels,
// fed through a one-entry valid/ready holding register with a sticky underrun flag.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [SAMPLE_W-1:0] sample_data,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                underrun_clr,
  output logic                underrun,
  output logic                BCLK,
  output logic                LRCLK,
  output logic                SDATA
);
  logic                  fall;
  logic                  load;
  logic                  accept;
  bit_idx_t              bit_cnt;
  bit_idx_t              bit_nxt;
  logic [FRAME_BITS-1:0] shreg;
  sample_t               hold;
  logic                  hold_full;

  bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bclk (BCLK),
    .fall (fall)
  );

  assign bit_nxt      = bit_cnt + BIT_CNT_W'(1);
  assign load         = fall && (bit_nxt == '0);
  assign accept       = sample_valid && !hold_full;
  assign sample_ready = ~hold_full;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      bit_cnt   <= '1;
      LRCLK     <= LR_LEFT;
      SDATA     <= 1'b0;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (fall) begin
        bit_cnt <= bit_nxt;
        LRCLK   <= lr_for_bit(bit_nxt);
        // Load emits the left MSB now and queues the rest of left plus the whole right word.
        if (load) begin
          SDATA <= hold[SAMPLE_W-1];
          shreg <= {hold[SAMPLE_W-2:0], hold, 1'b0};
        end else begin
          SDATA <= shreg[FRAME_BITS-1];
          shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
        end
      end
      // A sample arriving on an empty-register load waits for the next frame (no bypass).
      if (accept) begin
        hold      <= sample_data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (load && !hold_full) underrun <= 1'b1;
      else if (underrun_clr)  underrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_audio_i2s_tx.sv
// Randomised bench for audio_i2s_tx at CLK_DIV=2 and CLK_DIV=1 against a frame-level model
// derived from bit-slot arithmetic on the cycle count since reset.
module tb_audio_i2s_tx;
  localparam int N = 2;
  localparam int M_RESET = 0, M_CONST = 1, M_SEQ = 2, M_STARVE = 3, M_CLR = 4,
                 M_SYNC = 5, M_RSTMID = 6, M_RAND = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]       rst_n, valid, clr, ready, urun, bclk, lrclk, sdata;
  logic [N-1:0][15:0] data;

  audio_i2s_tx #(.CLK_DIV(2)) u_tx_d2 (
    .CLK(clk), .RST_N(rst_n[0]), .sample_data(data[0]), .sample_valid(valid[0]),
    .sample_ready(ready[0]), .underrun_clr(clr[0]), .underrun(urun[0]),
    .BCLK(bclk[0]), .LRCLK(lrclk[0]), .SDATA(sdata[0]));

  audio_i2s_tx #(.CLK_DIV(1)) u_tx_d1 (
    .CLK(clk), .RST_N(rst_n[1]), .sample_data(data[1]), .sample_valid(valid[1]),
    .sample_ready(ready[1]), .underrun_clr(clr[1]), .underrun(urun[1]),
    .BCLK(bclk[1]), .LRCLK(lrclk[1]), .SDATA(sdata[1]));

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: t = posedges since reset release; frame position follows from t alone.
  int          t[N];
  logic [15:0] m_hold[N], m_cur[N];
  bit          m_full[N], m_ur[N], m_bclk[N], m_lr[N], m_sd[N];
  int          sidx[N];
  bit          rst_done[N];

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic [15:0] seq_val(input int idx);
    if (idx == 0) return 16'hA55A;
    if (idx == 1) return 16'h0001;
    return 16'(idx * 16'h1357);
  endfunction

  // Advance the model across the coming posedge using the inputs just driven.
  task automatic step(input int i);
    int d, k;
    bit ld, acc;
    d  = div_of(i);
    ld = 1'b0;
    if (!rst_n[i]) begin
      t[i] = 0; m_hold[i] = '0; m_cur[i] = '0; m_full[i] = 0; m_ur[i] = 0;
      m_bclk[i] = 0; m_lr[i] = 0; m_sd[i] = 0;
      return;
    end
    t[i]++;
    acc       = valid[i] && !m_full[i];
    m_bclk[i] = ((t[i] / d) % 2) == 1;
    if (t[i] % (2 * d) == 0) begin
      k       = (t[i] / (2 * d) - 1) % 32;
      m_lr[i] = (k >= 15 && k <= 30);
      if (k == 0) begin
        ld = 1'b1;
        if (m_full[i]) m_cur[i] = m_hold[i];
      end
      m_sd[i] = m_cur[i][15 - (k % 16)];
    end
    if (ld && !m_full[i]) m_ur[i] = 1;
    else if (clr[i])      m_ur[i] = 0;
    if (acc) begin
      m_hold[i] = data[i];
      m_full[i] = 1;
      sidx[i]++;
    end else if (ld) begin
      m_full[i] = 0;
    end
  endtask

  task automatic drive(input int i, input int mode);
    int d, nt;
    d        = div_of(i);
    nt       = t[i] + 1;
    rst_n[i] = 1'b1;
    clr[i]   = 1'b0;
    valid[i] = 1'b0;
    case (mode)
      M_RESET:  rst_n[i] = 1'b0;
      M_CONST:  begin valid[i] = 1'b1; data[i] = 16'h3FFF; end
      M_SEQ:    begin valid[i] = 1'b1; data[i] = seq_val(sidx[i]); end
      M_STARVE: valid[i] = 1'b0;
      M_CLR:    clr[i] = 1'b1;
      M_SYNC: begin
        if (nt % (2 * d) == 0 && ((nt / (2 * d) - 1) % 32) == 0 && !m_full[i]) begin
          valid[i] = 1'b1;
          data[i]  = 16'($urandom);
        end
      end
      M_RSTMID: begin
        valid[i] = 1'b1;
        data[i]  = 16'hC0DE;
        if (!rst_done[i] && t[i] > 2 * d && ((t[i] / (2 * d) - 1) % 32) == 20) begin
          rst_n[i]    = 1'b0;
          rst_done[i] = 1'b1;
        end
      end
      default: begin
        valid[i] = ($urandom_range(0, 3) != 0);
        data[i]  = 16'($urandom);
        clr[i]   = ($urandom_range(0, 15) == 0);
      end
    endcase
  endtask

  task automatic run(input int mode, input int cycles);
    for (int i = 0; i < N; i++) begin
      sidx[i]     = 0;
      rst_done[i] = 1'b0;
    end
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++) begin
        drive(i, mode);
        step(i);
      end
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        check($sformatf("div%0d m%0d BCLK", div_of(i), mode),  16'(bclk[i]),  16'(m_bclk[i]));
        check($sformatf("div%0d m%0d LRCLK", div_of(i), mode), 16'(lrclk[i]), 16'(m_lr[i]));
        check($sformatf("div%0d m%0d SDATA", div_of(i), mode), 16'(sdata[i]), 16'(m_sd[i]));
        check($sformatf("div%0d m%0d ready", div_of(i), mode), 16'(ready[i]), 16'(!m_full[i]));
        check($sformatf("div%0d m%0d underrun", div_of(i), mode), 16'(urun[i]), 16'(m_ur[i]));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      t[i] = 0; sidx[i] = 0; rst_done[i] = 0; data[i] = '0;
    end
    run(M_RESET, 3);
    run(M_CONST, 300);
    run(M_SEQ, 400);
    run(M_STARVE, 300);
    run(M_CLR, 1);
    run(M_CONST, 300);
    run(M_STARVE, 150);
    run(M_SYNC, 400);
    run(M_RSTMID, 300);
    run(M_RESET, 2);
    run(M_RAND, 3000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Serialises 16-bit mono audio samples into a standard Philips I2S stream (BCLK, LRCLK, SDATA) for an external audio DAC/codec. Sits directly downstream of the tone/oscillator sources in the audio peripheral and consumes their 16-bit `data` word through a one-entry valid/ready holding register. Each accepted sample is transmitted on both left and right channels of one 32-bit frame. A sticky flag reports frames sent without fresh data (underrun).

## Interface
- `CLK_DIV`, default 4: CLK cycles per BCLK half-period; legal range ≥1. BCLK = CLK/(2·CLK_DIV).
- `CLK`  in  1  system clock; all logic on posedge.
- `RST_N`  in  1  synchronous, active-low reset.
- `sample_data`  in  16  two's-complement sample, MSB first on the wire.
- `sample_valid`  in  1  `sample_data` valid; tie high for free-running sources.
- `sample_ready`  out  1  holding register empty; transfer occurs on `sample_valid && sample_ready`.
- `underrun_clr`  in  1  single-cycle clear of `underrun`.
- `underrun`  out  1  sticky: a frame started with the holding register empty.
- `BCLK`  out  1  I2S bit clock, registered.
- `LRCLK`  out  1  word select, 0 = left, 1 = right; registered.
- `SDATA`  out  1  serial data, changes only on BCLK falling edge; registered.

## Operation
- Divider `div_cnt` counts 0..CLK_DIV-1; at CLK_DIV-1 it wraps and BCLK toggles. A toggle 1→0 is a "fall event" (internal one-cycle strobe, same cycle BCLK register goes low).
- `bit_cnt` (5 bits) increments mod 32 on every fall event; all SDATA/LRCLK updates happen only on fall events.
- LRCLK on fall event: 1 if new `bit_cnt` ∈ 15..30, else 0 (changes one BCLK before each channel MSB, per I2S).
- Frame load (fall event with new `bit_cnt` = 0): SDATA ← hold[15]; 32-bit shift reg ← {hold[14:0], hold, 1'b0}. Other fall events: SDATA ← shreg[31], shreg ← shreg<<1. Left MSB at `bit_cnt` 0, right MSB at 16.
- Holding register: `sample_ready` = !hold_full. Accept sets hold_full and captures data. Frame load clears hold_full.
- Underrun: frame load with hold_full = 0 → retransmit last held value (zero after reset), set `underrun`. No bypass: a sample accepted in the same cycle as an empty-register frame load is not used in that frame; it is sent next frame.
- `underrun_clr` clears the flag; if a new underrun occurs in the same cycle, set wins.
- Reset (any time, including mid-frame): div_cnt 0, bit_cnt 31, BCLK 0, LRCLK 0, SDATA 0, shreg 0, hold 0, hold_full 0 (`sample_ready` 1), `underrun` 0. Partial frame discarded; no glitch beyond forcing outputs low.

## Timing
- After RST_N deasserts, first BCLK rise at CLK_DIV cycles, first fall event (frame load, bit 0) at 2·CLK_DIV cycles.
- Frame = 32 BCLK = 64·CLK_DIV CLK cycles; one sample consumed per frame.
- Latency: sample accepted before a frame load appears as SDATA MSB in that load cycle's registered output (next CLK edge visible).
- `sample_ready` deasserts the cycle after acceptance; reasserts the cycle after frame load.
- Outputs held stable between fall/toggle events; DAC samples SDATA on BCLK rise, mid-bit.

## Structure
- Shared package `audio_pkg`: `SAMPLE_W` = 16, `FRAME_BITS` = 32, `LR_LEFT` = 0 / `LR_RIGHT` = 1, shared with oscillator and future mixer blocks.
- One sub-module `bclk_gen` (divider, BCLK register, fall-event strobe, parameter CLK_DIV). Shifter, holding register, counters in top level.

## Test plan
- Reset, CLK_DIV=2, `sample_valid`=1, data 16'h3FFF: first fall at CLK 4; SDATA per frame = 0,0,1×14 left then same right; LRCLK high for bit_cnt 15..30; `underrun` stays 0.
- Pattern 16'hA55A then 16'h0001 back-to-back: frames bit-exact MSB-first, both channels identical, frame spacing 128 CLK.
- `sample_valid`=0 after one sample: next frame retransmits same value, `underrun`=1; pulse `underrun_clr` → 0; stays 0 once valid restored.
- `sample_valid` rises in exact cycle of empty frame load: `underrun`=1, new sample appears in following frame, not current.
- RST_N low for 1 CLK mid-right-channel: BCLK/LRCLK/SDATA 0 next cycle, `sample_ready`=1; restart timing identical to power-on case.
- CLK_DIV=1: BCLK toggles every CLK, frame = 64 CLK, data correct.
